// File: rtl/rv_decoder_if.sv
// Fetch-to-decoder bundle: instruction slot and flow control in, decoded slot out.
interface rv_decoder_if #(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int INST = 32
);
  logic [ADDR-1:0] inst_pc;
  logic [INST-1:0] inst;
  logic            inst_e_;
  logic            stall;
  logic            is_full;
  logic            dec_e_out_;
  logic [5:0]      rs1_out;
  logic [5:0]      rs2_out;
  logic [5:0]      rd_out;
  logic            invalid_out;
  logic [DATA:0]   imm_data_out;
  logic [2:0]      unit_out;
  logic [3:0]      command_out;

  modport master (
    output inst_pc, inst, inst_e_, stall, is_full,
    input  dec_e_out_, rs1_out, rs2_out, rd_out, invalid_out,
           imm_data_out, unit_out, command_out
  );

  modport slave (
    input  inst_pc, inst, inst_e_, stall, is_full,
    output dec_e_out_, rs1_out, rs2_out, rd_out, invalid_out,
           imm_data_out, unit_out, command_out
  );
endinterface

// File: rtl/rv_decoder.sv
// Single-stage registered RV32I decoder; define RV_M_EXT_EN to also decode the
// M extension (MUL/DIV) instead of treating funct7=0000001 as illegal.
module rv_decoder #(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int INST = 32
) (
  input  logic         clk,
  input  logic         reset,
  rv_decoder_if.slave  bus
);
  typedef enum logic [2:0] {
    U_ALU = 3'd0, U_BR = 3'd1, U_MEM = 3'd2, U_MUL = 3'd3,
    U_DIV = 3'd4, U_CSR = 3'd5, U_NONE = 3'd7
  } unit_e;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] a_rd, a_rs2, a_rs1;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = bus.inst[6:0];
  assign a_rd  = bus.inst[11:7];
  assign f3    = bus.inst[14:12];
  assign a_rs1 = bus.inst[19:15];
  assign a_rs2 = bus.inst[24:20];
  assign f7    = bus.inst[31:25];
  assign imm_i = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign imm_s = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
  assign imm_b = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7], bus.inst[30:25], bus.inst[11:8], 1'b0};
  assign imm_u = {bus.inst[31:12], 12'b0};
  assign imm_j = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12], bus.inst[20], bus.inst[30:21], 1'b0};

  logic            rs1_v, rs2_v, rd_w, imm_v, illegal;
  logic [4:0]      rs1_a;
  logic [DATA-1:0] imm_val;
  unit_e           unit;
  logic [3:0]      cmd;

  always_comb begin
    rs1_v   = 1'b0;
    rs2_v   = 1'b0;
    rd_w    = 1'b0;
    imm_v   = 1'b0;
    illegal = 1'b0;
    rs1_a   = a_rs1;
    imm_val = '0;
    unit    = U_NONE;
    cmd     = 4'd0;
    // The opcode match includes inst[1:0]=11, so compressed encodings fall to default.
    case (opc)
      OPC_OP: begin
        rs1_v = 1'b1; rs2_v = 1'b1; rd_w = 1'b1;
        unit  = U_ALU; cmd = {1'b0, f3};
        if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) cmd[3] = 1'b1;
`ifdef RV_M_EXT_EN
        else if (f7 == 7'b0000001) unit = f3[2] ? U_DIV : U_MUL;
`endif
        else if (f7 != 7'b0000000) illegal = 1'b1;
      end
      OPC_IMM: begin
        rs1_v = 1'b1; rd_w = 1'b1; imm_v = 1'b1;
        unit  = U_ALU; cmd = {1'b0, f3};
        imm_val = DATA'(imm_i);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm_val = DATA'(a_rs2);
          if (f3 == 3'b101 && f7 == 7'b0100000) cmd[3] = 1'b1;
          else if (f7 != 7'b0000000) illegal = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        rs1_v = 1'b1; rs1_a = 5'd0; rd_w = 1'b1; imm_v = 1'b1;
        unit  = U_ALU;
        imm_val = (opc == OPC_LUI) ? DATA'(imm_u) : DATA'(bus.inst_pc) + DATA'(imm_u);
      end
      OPC_JAL: begin
        rd_w = 1'b1; imm_v = 1'b1; unit = U_BR; imm_val = DATA'(imm_j);
      end
      OPC_JALR: begin
        rs1_v = 1'b1; rd_w = 1'b1; imm_v = 1'b1; unit = U_BR; cmd = 4'b0001;
        imm_val = DATA'(imm_i);
        illegal = (f3 != 3'b000);
      end
      OPC_BR: begin
        rs1_v = 1'b1; rs2_v = 1'b1; imm_v = 1'b1; unit = U_BR; cmd = {1'b1, f3};
        imm_val = DATA'(imm_b);
        illegal = (f3 == 3'b010 || f3 == 3'b011);
      end
      OPC_LOAD: begin
        rs1_v = 1'b1; rd_w = 1'b1; imm_v = 1'b1; unit = U_MEM; cmd = {1'b0, f3};
        imm_val = DATA'(imm_i);
        illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      OPC_STORE: begin
        rs1_v = 1'b1; rs2_v = 1'b1; imm_v = 1'b1; unit = U_MEM; cmd = {1'b1, f3};
        imm_val = DATA'(imm_s);
        illegal = f3[2] || (f3 == 3'b011);
      end
      OPC_FENCE: begin
        unit = U_MEM; cmd = 4'b1111;
      end
      OPC_SYS: begin
        unit = U_CSR;
        if (f3 == 3'b000) begin
          if (bus.inst[31:20] == 12'd0)      cmd = 4'b1000;
          else if (bus.inst[31:20] == 12'd1) cmd = 4'b1001;
          else                               illegal = 1'b1;
        end else begin
          // For the immediate CSR forms the rs1 field carries zimm, not a register.
          rs1_v = ~f3[2]; rd_w = 1'b1; imm_v = 1'b1; cmd = {1'b0, f3};
          imm_val = DATA'({a_rs1, bus.inst[31:20]});
          illegal = (f3 == 3'b100);
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  logic            dec_e_d, dec_e_q, invalid_d, invalid_q;
  logic [5:0]      rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [DATA:0]   imm_d, imm_q;
  logic [2:0]      unit_d, unit_q;
  logic [3:0]      cmd_d, cmd_q;
  logic            advance;

  assign advance = !bus.stall && !bus.is_full;

  always_comb begin
    dec_e_d   = dec_e_q;
    invalid_d = invalid_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    unit_d    = unit_q;
    cmd_d     = cmd_q;
    if (advance) begin
      dec_e_d   = bus.inst_e_;
      invalid_d = illegal && !bus.inst_e_;
      if (illegal) begin
        rs1_d  = '0;
        rs2_d  = '0;
        rd_d   = '0;
        imm_d  = '0;
        unit_d = U_NONE;
        cmd_d  = 4'd0;
      end else begin
        rs1_d  = rs1_v ? {1'b1, rs1_a} : 6'd0;
        rs2_d  = rs2_v ? {1'b1, a_rs2} : 6'd0;
        rd_d   = (rd_w && a_rd != 5'd0) ? {1'b1, a_rd} : 6'd0;
        imm_d  = imm_v ? {1'b1, imm_val} : '0;
        unit_d = unit;
        cmd_d  = cmd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_e_q   <= 1'b1;
      invalid_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      unit_q    <= U_NONE;
      cmd_q     <= 4'd0;
    end else begin
      dec_e_q   <= dec_e_d;
      invalid_q <= invalid_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      unit_q    <= unit_d;
      cmd_q     <= cmd_d;
    end
  end

  assign bus.dec_e_out_   = dec_e_q;
  assign bus.invalid_out  = invalid_q;
  assign bus.rs1_out      = rs1_q;
  assign bus.rs2_out      = rs2_q;
  assign bus.rd_out       = rd_q;
  assign bus.imm_data_out = imm_q;
  assign bus.unit_out     = unit_q;
  assign bus.command_out  = cmd_q;
endmodule

// File: tb/tb_rv_decoder.sv
// Directed scoreboard bench for rv_decoder: expected decodes are queued as each
// instruction is driven and checked when the registered result appears.
module tb_rv_decoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_decoder_if #(.ADDR(32), .DATA(32), .INST(32)) bus ();
  rv_decoder #(.ADDR(32), .DATA(32), .INST(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        dec_e;
    logic        inv;
    logic [5:0]  rs1, rs2, rd;
    logic [32:0] imm;
    logic [2:0]  unit;
    logic [3:0]  cmd;
    bit          full;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int n_vec = 0;
  int n_err = 0;

  function automatic exp_t mk(logic [5:0] rs1, logic [5:0] rs2, logic [5:0] rd,
                              logic [32:0] imm, logic [2:0] unit, logic [3:0] cmd);
    exp_t e;
    e.dec_e = 1'b0; e.inv = 1'b0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.imm = imm; e.unit = unit; e.cmd = cmd; e.full = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_inv();
    exp_t e = mk(6'd0, 6'd0, 6'd0, 33'd0, 3'd7, 4'd0);
    e.inv = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_rst();
    exp_t e = mk(6'd0, 6'd0, 6'd0, 33'd0, 3'd7, 4'd0);
    e.dec_e = 1'b1;
    return e;
  endfunction

  task automatic cmp(string tag, logic [32:0] obs, logic [32:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_out(string tag, exp_t e);
    cmp({tag, ".dec_e"}, 33'(bus.dec_e_out_), 33'(e.dec_e));
    cmp({tag, ".invalid"}, 33'(bus.invalid_out), 33'(e.inv));
    if (e.full) begin
      cmp({tag, ".rs1"}, 33'(bus.rs1_out), 33'(e.rs1));
      cmp({tag, ".rs2"}, 33'(bus.rs2_out), 33'(e.rs2));
      cmp({tag, ".rd"}, 33'(bus.rd_out), 33'(e.rd));
      cmp({tag, ".imm"}, bus.imm_data_out, e.imm);
      cmp({tag, ".unit"}, 33'(bus.unit_out), 33'(e.unit));
      cmp({tag, ".cmd"}, 33'(bus.command_out), 33'(e.cmd));
    end
  endtask

  task automatic step(string tag, logic [31:0] i, logic [31:0] pc, logic e_, exp_t e);
    @(negedge clk);
    bus.inst = i; bus.inst_pc = pc; bus.inst_e_ = e_;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      last = sb.pop_front();
      check_out(tag, last);
    end
  endtask

  task automatic hold(string tag, logic st, logic fu, logic [31:0] i);
    @(negedge clk);
    bus.stall = st; bus.is_full = fu; bus.inst = i; bus.inst_e_ = 1'b0;
    @(posedge clk); #1;
    check_out(tag, last);
  endtask

  exp_t e_tmp;

  initial begin
    reset = 1'b1;
    bus.inst = 32'd0; bus.inst_pc = 32'd0; bus.inst_e_ = 1'b1;
    bus.stall = 1'b0; bus.is_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_out("reset", mk_rst());
    @(negedge clk) reset = 1'b0;

    step("add",    32'h002081B3, 32'h0, 1'b0, mk(6'h21, 6'h22, 6'h23, 33'h0, 3'd0, 4'h0));
    step("addi",   32'hFFF00093, 32'h0, 1'b0, mk(6'h20, 6'h00, 6'h21, 33'h1_FFFF_FFFF, 3'd0, 4'h0));
    step("slli25", 32'h02009093, 32'h0, 1'b0, mk_inv());
    step("srai",   32'h4020D093, 32'h0, 1'b0, mk(6'h21, 6'h00, 6'h21, 33'h1_0000_0002, 3'd0, 4'hD));
    step("auipc",  32'h00001297, 32'h1000, 1'b0, mk(6'h20, 6'h00, 6'h25, 33'h1_0000_2000, 3'd0, 4'h0));
    hold("stall",      1'b1, 1'b0, 32'h00000013);
    hold("stall_full", 1'b1, 1'b1, 32'h402081B3);
    hold("full",       1'b0, 1'b1, 32'h0050A423);
    @(negedge clk) bus.is_full = 1'b0;
    step("sub",    32'h402081B3, 32'h0, 1'b0, mk(6'h21, 6'h22, 6'h23, 33'h0, 3'd0, 4'h8));
`ifdef RV_M_EXT_EN
    step("mul",    32'h022081B3, 32'h0, 1'b0, mk(6'h21, 6'h22, 6'h23, 33'h0, 3'd3, 4'h0));
`else
    step("mul",    32'h022081B3, 32'h0, 1'b0, mk_inv());
`endif
    step("opf7",   32'h202081B3, 32'h0, 1'b0, mk_inv());
    step("lui",    32'h123452B7, 32'h0, 1'b0, mk(6'h20, 6'h00, 6'h25, 33'h1_1234_5000, 3'd0, 4'h0));
    step("beq",    32'h00208463, 32'h0, 1'b0, mk(6'h21, 6'h22, 6'h00, 33'h1_0000_0008, 3'd1, 4'h8));
    step("br010",  32'h0020A463, 32'h0, 1'b0, mk_inv());
    step("lw",     32'hFFC12203, 32'h0, 1'b0, mk(6'h22, 6'h00, 6'h24, 33'h1_FFFF_FFFC, 3'd2, 4'h2));
    step("sw",     32'h0050A423, 32'h0, 1'b0, mk(6'h21, 6'h25, 6'h00, 33'h1_0000_0008, 3'd2, 4'hA));
    step("jal",    32'h010000EF, 32'h0, 1'b0, mk(6'h00, 6'h00, 6'h21, 33'h1_0000_0010, 3'd1, 4'h0));
    step("jalr",   32'h00008067, 32'h0, 1'b0, mk(6'h21, 6'h00, 6'h00, 33'h1_0000_0000, 3'd1, 4'h1));
    step("csrrw",  32'h300110F3, 32'h0, 1'b0, mk(6'h22, 6'h00, 6'h21, 33'h1_0000_2300, 3'd5, 4'h1));
    step("csrrwi", 32'h3002D0F3, 32'h0, 1'b0, mk(6'h00, 6'h00, 6'h21, 33'h1_0000_5300, 3'd5, 4'h5));
    step("ecall",  32'h00000073, 32'h0, 1'b0, mk(6'h00, 6'h00, 6'h00, 33'h0, 3'd5, 4'h8));
    step("ebreak", 32'h00100073, 32'h0, 1'b0, mk(6'h00, 6'h00, 6'h00, 33'h0, 3'd5, 4'h9));
    step("sys100", 32'h00004073, 32'h0, 1'b0, mk_inv());
    step("fence",  32'h0FF0000F, 32'h0, 1'b0, mk(6'h00, 6'h00, 6'h00, 33'h0, 3'd2, 4'hF));
    step("lo_bits", 32'h00000000, 32'h0, 1'b0, mk_inv());
    e_tmp = mk_rst(); e_tmp.full = 1'b0;
    step("slot_off", 32'h00000000, 32'h0, 1'b1, e_tmp);
    step("add2",   32'h002081B3, 32'h0, 1'b0, mk(6'h21, 6'h22, 6'h23, 33'h0, 3'd0, 4'h0));

    // Asynchronous reset while the queue is full, checked before the next rising edge.
    @(negedge clk) bus.is_full = 1'b1;
    #2 reset = 1'b1;
    #1 check_out("async_rst", mk_rst());
    @(posedge clk); #1;
    check_out("rst_hold", mk_rst());
    @(negedge clk) begin reset = 1'b0; bus.is_full = 1'b0; end
    sb.delete();
    step("post_rst", 32'hFFF00093, 32'h0, 1'b0, mk(6'h20, 6'h00, 6'h21, 33'h1_FFFF_FFFF, 3'd0, 4'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
